// File: rtl/axi4l_pkg.sv
// Shared types and constants for the AXI4-Lite write master.
// Used by axi4l_wr_master and, when AXI4L_WR_TIMEOUT_EN is defined, axi4l_wdog.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR_DATA,
    WAIT_B
  } wr_state_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both have the upper response bit set.
  function automatic logic isErrResp(input logic [1:0] r);
    return r[1];
  endfunction

endpackage

// File: rtl/axi4l_wdog.sv
// Transaction watchdog for the AXI4-Lite write master.
// Built only when AXI4L_WR_TIMEOUT_EN is defined.
// count_q holds the number of cycles since the command was accepted.
// timeout_o rises in the cycle where that count reaches TIMEOUT_CYC.
// timeout_o is sticky until the next command start.
module axi4l_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic timeout_o
);

  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYC);

  logic [CntW-1:0] count_q, count_d;
  logic            timeout_q, timeout_d;

  // Next-state for the saturating cycle counter and the sticky flag.
  // The count restarts at 1 on a command start and clears while idle.
  always_comb begin
    count_d   = '0;
    timeout_d = timeout_q;
    if (start_i) begin
      count_d   = CntW'(1);
      timeout_d = 1'b0;
    end else if (run_i) begin
      count_d = (count_q == Limit) ? count_q : count_q + 1'b1;
    end
    if ((start_i || run_i) && (count_d == Limit)) begin
      timeout_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/axi4l_wr_master.sv
// AXI4-Lite write-only master with one transaction outstanding.
// It takes a command and issues AW and W with independent handshakes.
// It then collects B and pulses done, or done with err, on completion.
// Optional watchdog: define AXI4L_WR_TIMEOUT_EN to build axi4l_wdog.
// Without that macro, timeout is tied to 0.
module axi4l_wr_master
  import axi4l_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              done,
  output logic [1:0]        resp,
  output logic              err,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic              timeout
);

  wr_state_t         state_q;
  logic [ADDR_W-1:0] awAddr_q;
  logic [DATA_W-1:0] wData_q;
  logic [STRB_W-1:0] wStrb_q;
  logic              awValid_q, wValid_q, bReady_q;
  logic              awDone_q, wDone_q;
  logic              done_q, err_q;
  resp_t             resp_q;

  logic              accept;
  logic              awDoneNow, wDoneNow;

  // The done cycle is kept out of acceptance, so the next command lands one cycle after done.
  assign cmd_ready = (state_q == IDLE) && !done_q && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // A channel counts as finished if it already completed or is handshaking this cycle.
  assign awDoneNow = awDone_q || (awValid_q && AWREADY);
  assign wDoneNow  = wDone_q  || (wValid_q  && WREADY);

  // Transaction FSM; every AXI-facing output comes straight from a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      awValid_q <= 1'b0;
      wValid_q  <= 1'b0;
      bReady_q  <= 1'b0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      resp_q    <= OKAY;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            awAddr_q  <= cmd_addr;
            wData_q   <= cmd_data;
            wStrb_q   <= cmd_strb;
            awValid_q <= 1'b1;
            wValid_q  <= 1'b1;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
            state_q   <= ADDR_DATA;
          end
        end
        ADDR_DATA: begin
          if (awValid_q && AWREADY) awValid_q <= 1'b0;
          if (wValid_q && WREADY)   wValid_q  <= 1'b0;
          if (awDoneNow && wDoneNow) begin
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
            bReady_q <= 1'b1;
            state_q  <= WAIT_B;
          end else begin
            awDone_q <= awDoneNow;
            wDone_q  <= wDoneNow;
          end
        end
        WAIT_B: begin
          if (BVALID && bReady_q) begin
            bReady_q <= 1'b0;
            resp_q   <= resp_t'(BRESP);
            done_q   <= 1'b1;
            err_q    <= isErrResp(BRESP);
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AWADDR  = awAddr_q;
  assign AWPROT  = AXI_PROT_DEFAULT;
  assign AWVALID = awValid_q;
  assign WDATA   = wData_q;
  assign WSTRB   = wStrb_q;
  assign WVALID  = wValid_q;
  assign BREADY  = bReady_q;
  assign done    = done_q;
  assign err     = err_q;
  assign resp    = resp_q;

`ifdef AXI4L_WR_TIMEOUT_EN
  axi4l_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept),
    .run_i    (state_q != IDLE),
    .timeout_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi4l_wr_master.sv
// Directed testbench for axi4l_wr_master.
// The DUT is built with DATA_W=64 and TIMEOUT_CYC=16.
// Cycle k means the period that ends at the k-th rising edge after the command is presented.
// Inputs are driven and outputs sampled on the falling edge.
module tb_axi4l_wr_master;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 64;
  localparam int STRB_W      = DATA_W / 8;
  localparam int TIMEOUT_CYC = 16;
`ifdef AXI4L_WR_TIMEOUT_EN
  localparam logic TimeoutEn = 1'b1;
`else
  localparam logic TimeoutEn = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [STRB_W-1:0] cmd_strb;
  logic              done;
  logic [1:0]        resp;
  logic              err;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic              timeout;

  int checkCount = 0;
  int passCount  = 0;
  int doneCount  = 0;
  int doneBefore;

  axi4l_wr_master #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_strb (cmd_strb),
    .done     (done),
    .resp     (resp),
    .err      (err),
    .AWADDR   (AWADDR),
    .AWPROT   (AWPROT),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .timeout  (timeout)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse so that abandoned transactions can be shown to produce none.
  always @(posedge clk) begin
    if (done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_strb  = strb;
  endtask

  // Directed test sequence.
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;

    // Check that every output holds its reset value while reset is asserted.
    repeat (3) nextCycle();
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_awvalid",   AWVALID,   0);
    checkOutput("rst_wvalid",    WVALID,    0);
    checkOutput("rst_bready",    BREADY,    0);
    checkOutput("rst_done",      done,      0);
    checkOutput("rst_resp",      resp,      0);
    checkOutput("rst_err",       err,       0);
    checkOutput("rst_awaddr",    AWADDR,    0);
    checkOutput("rst_wdata",     WDATA,     0);
    checkOutput("rst_wstrb",     WSTRB,     0);
    checkOutput("rst_timeout",   timeout,   0);
    rst = 1'b0;
    nextCycle();
    checkOutput("idle_cmd_ready", cmd_ready, 1);

    // Assert reset mid-transaction with both READYs low.
    applyStimulus(32'h40, 64'h1111, 8'hFF);
    nextCycle();
    cmd_valid = 1'b0;
    checkOutput("mid_awvalid_up", AWVALID, 1);
    doneBefore = doneCount;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_awvalid", AWVALID,   0);
    checkOutput("mid_rst_wvalid",  WVALID,    0);
    checkOutput("mid_rst_bready",  BREADY,    0);
    checkOutput("mid_rst_ready",   cmd_ready, 0);
    repeat (3) nextCycle();
    rst = 1'b0;
    nextCycle();
    checkOutput("mid_rel_ready",   cmd_ready, 1);
    checkOutput("mid_rel_awvalid", AWVALID,   0);
    checkOutput("mid_no_done",     doneCount, doneBefore);

    // Single write at minimum latency: READYs and BVALID are already high.
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    applyStimulus(32'h0000_0010, 64'hDEAD_FEED, 8'hFF);
    nextCycle();
    cmd_valid = 1'b0;
    checkOutput("sw_c1_awvalid", AWVALID, 1);
    checkOutput("sw_c1_wvalid",  WVALID,  1);
    checkOutput("sw_c1_awaddr",  AWADDR,  32'h10);
    checkOutput("sw_c1_wdata",   WDATA,   64'hDEAD_FEED);
    checkOutput("sw_c1_wstrb",   WSTRB,   8'hFF);
    checkOutput("sw_c1_awprot",  AWPROT,  0);
    checkOutput("sw_c1_bready",  BREADY,  0);
    nextCycle();
    checkOutput("sw_c2_awvalid", AWVALID, 0);
    checkOutput("sw_c2_wvalid",  WVALID,  0);
    checkOutput("sw_c2_bready",  BREADY,  1);
    checkOutput("sw_c2_done",    done,    0);
    nextCycle();
    checkOutput("sw_c3_done",    done,      1);
    checkOutput("sw_c3_resp",    resp,      2'b00);
    checkOutput("sw_c3_err",     err,       0);
    checkOutput("sw_c3_bready",  BREADY,    0);
    checkOutput("sw_c3_ready",   cmd_ready, 0);
    nextCycle();
    checkOutput("sw_c4_done",    done,      0);
    checkOutput("sw_c4_ready",   cmd_ready, 1);

    // W completes before AW. BVALID is held high early and must be ignored.
    AWREADY = 1'b0; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    applyStimulus(32'h24, 64'hCAFE_0000_1234_5678, 8'hF0);
    nextCycle();
    cmd_valid = 1'b0;
    checkOutput("wa_c1_awvalid", AWVALID, 1);
    checkOutput("wa_c1_wvalid",  WVALID,  1);
    nextCycle();
    checkOutput("wa_c2_wvalid",  WVALID,  0);
    checkOutput("wa_c2_awvalid", AWVALID, 1);
    checkOutput("wa_c2_bready",  BREADY,  0);
    for (int c = 3; c <= 5; c++) begin
      nextCycle();
      checkOutput("wa_hold_awvalid", AWVALID, 1);
      checkOutput("wa_hold_awaddr",  AWADDR,  32'h24);
      checkOutput("wa_hold_bready",  BREADY,  0);
      checkOutput("wa_hold_done",    done,    0);
    end
    AWREADY = 1'b1;
    nextCycle();
    checkOutput("wa_c6_awvalid", AWVALID, 0);
    checkOutput("wa_c6_bready",  BREADY,  1);
    nextCycle();
    checkOutput("wa_c7_done",    done,    1);
    checkOutput("wa_c7_wstrb",   WSTRB,   8'hF0);

    // A DECERR response pulses done and err, and resp stays at 3.
    nextCycle();
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b11;
    applyStimulus(32'h30, 64'h55AA, 8'h01);
    nextCycle();
    cmd_valid = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("er_c3_done", done, 1);
    checkOutput("er_c3_err",  err,  1);
    checkOutput("er_c3_resp", resp, 2'b11);
    nextCycle();
    checkOutput("er_c4_done", done, 0);
    checkOutput("er_c4_err",  err,  0);
    repeat (3) nextCycle();
    checkOutput("er_resp_held", resp, 2'b11);

    // Back-to-back commands with cmd_valid held high and a partial strobe.
    BRESP = 2'b00;
    applyStimulus(32'h100, 64'h0123_4567_89AB_CDEF, 8'h0F);
    nextCycle();
    applyStimulus(32'h104, 64'hFEDC_BA98_7654_3210, 8'h0F);
    checkOutput("bb_c1_ready", cmd_ready, 0);
    checkOutput("bb_c1_wstrb", WSTRB,     8'h0F);
    checkOutput("bb_c1_wdata", WDATA,     64'h0123_4567_89AB_CDEF);
    nextCycle();
    checkOutput("bb_c2_ready", cmd_ready, 0);
    nextCycle();
    checkOutput("bb_c3_done",    done,      1);
    checkOutput("bb_c3_resp",    resp,      2'b00);
    checkOutput("bb_c3_ready",   cmd_ready, 0);
    checkOutput("bb_c3_awvalid", AWVALID,   0);
    nextCycle();
    checkOutput("bb_c4_ready",   cmd_ready, 1);
    checkOutput("bb_c4_done",    done,      0);
    nextCycle();
    cmd_valid = 1'b0;
    checkOutput("bb_c5_awvalid", AWVALID, 1);
    checkOutput("bb_c5_awaddr",  AWADDR,  32'h104);
    checkOutput("bb_c5_wdata",   WDATA,   64'hFEDC_BA98_7654_3210);
    checkOutput("bb_c5_wstrb",   WSTRB,   8'h0F);
    nextCycle();
    checkOutput("bb_c6_bready",  BREADY,  1);
    nextCycle();
    checkOutput("bb_c7_done",    done,    1);
    nextCycle();

    // Withhold BVALID for 40 cycles to exercise the watchdog.
    BVALID = 1'b0;
    applyStimulus(32'h200, 64'h77, 8'hFF);
    for (int c = 1; c <= 40; c++) begin
      nextCycle();
      if (c == 1) cmd_valid = 1'b0;
      if (c == 15) checkOutput("to_c15_timeout", timeout, 0);
      if (c == 16) checkOutput("to_c16_timeout", timeout, TimeoutEn);
      if (c == 40) begin
        checkOutput("to_c40_timeout", timeout, TimeoutEn);
        checkOutput("to_c40_bready",  BREADY,  1);
        checkOutput("to_c40_done",    done,    0);
      end
    end
    BVALID = 1'b1;
    nextCycle();
    BVALID = 1'b0;
    checkOutput("to_c41_done",    done,    1);
    checkOutput("to_c41_timeout", timeout, TimeoutEn);
    nextCycle();
    applyStimulus(32'h204, 64'h88, 8'hFF);
    nextCycle();
    cmd_valid = 1'b0;
    checkOutput("to_new_timeout", timeout, 0);
    BVALID = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("to_new_done", done, 1);
    BVALID = 1'b0;
    nextCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axi4l_wr_master.md
Name: axi4l_wr_master

Overview:
Parametrised AXI4-Lite write-only master. It accepts write commands (address, data, strobe) on a valid/ready command port. It issues AW and W concurrently with independent handshakes, collects BRESP and reports completion status. One transaction is outstanding at a time. It sits between a local control FSM or register sequencer and an AXI4-Lite interconnect slave port.

Parameters:
ADDR_W, 32, AWADDR / cmd_addr width
DATA_W, 32, WDATA / cmd_data width; legal values 32 or 64
STRB_W, DATA_W/8, WSTRB / cmd_strb width (derived, not overridable)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept a command
cmd_addr  in  ADDR_W  write address
cmd_data  in  DATA_W  write data
cmd_strb  in  STRB_W  byte strobes
done  out  1  one-cycle completion pulse
resp  out  2  BRESP captured at completion
err  out  1  one-cycle pulse with done when resp is SLVERR or DECERR
AWADDR  out  ADDR_W  write address
AWPROT  out  3  constant 3'b000
AWVALID  out  1
AWREADY  in  1
WDATA  out  DATA_W
WSTRB  out  STRB_W
WVALID  out  1
WREADY  in  1
BRESP  in  2
BVALID  in  1
BREADY  out  1
timeout  out  1  sticky watchdog flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst high, asynchronous) returns the block to IDLE and sets all outputs to 0: AWADDR, WDATA, WSTRB, AWVALID, WVALID, BREADY, done, resp, err, timeout. cmd_ready also reads 0 during reset and is 1 in IDLE after reset.
- Reset mid-transaction abandons the transaction with no done pulse. All valids drop immediately.
- All AXI outputs are registered.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/data/strb into AWADDR/WDATA/WSTRB, set AWVALID=1 and WVALID=1, go to ADDR_DATA. AWVALID rises the cycle after acceptance.
  - ADDR_DATA: track aw_done and w_done flags.
    - AWVALID&AWREADY: clear AWVALID next cycle, set aw_done.
    - WVALID&WREADY: clear WVALID next cycle, set w_done.
    - Both may occur in the same cycle, and in either order.
    - When both are done, including when both complete in the same cycle, set BREADY=1 and go to WAIT_B.
  - WAIT_B: on BVALID&BREADY, capture BRESP into resp, drop BREADY, pulse done (and err if BRESP[1]=1) in the next cycle, go to IDLE.
- The next command can be accepted the cycle after done is pulsed.
- A VALID, once raised, is never dropped before its READY. Payload stays stable while VALID is high.
- Minimum latency, with READYs and BVALID already high: command accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, done at cycle 3.
- BVALID arriving before AW/W completes is ignored; BREADY stays 0 until WAIT_B.
- resp holds its value until the next completion.

Optional Feature:
Macro AXI4L_WR_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in ADDR_DATA and WAIT_B and clears on entry to IDLE.
  - When it reaches TIMEOUT_CYC, set timeout=1 (sticky). The handshake keeps waiting (no protocol violation).
  - timeout clears on the next command acceptance or on reset.
- Without the macro: no counter is built and timeout is constant 0.

Decomposition:
- Package axi4l_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - wr_state_t enum: IDLE, ADDR_DATA, WAIT_B
  - AXI_PROT_DEFAULT = 3'b000
- One sub-module, axi4l_wdog (the timeout counter), instantiated only under AXI4L_WR_TIMEOUT_EN.

Test Plan:
- Reset to idle: hold rst=1 for 3 cycles mid-ADDR_DATA -> all VALIDs/BREADY 0 immediately, cmd_ready=1 after release, no done pulse.
- Single write, READYs held at 1: cmd addr=32'h0000_0010, data=32'hDEADFEED, strb=4'hF; slave returns BVALID=1, BRESP=OKAY -> AWADDR/WDATA match, done at cycle 3, resp=2'b00, err=0.
- W before AW: WREADY=1 at cycle 1, AWREADY delayed to cycle 5 -> WVALID drops after cycle 1, AWVALID held stable with unchanged AWADDR through cycle 5, BREADY rises only after AW completes.
- Error response: BRESP=2'b11 -> done and err pulse together, resp=2'b11 held until the next completion.
- Back-to-back commands with cmd_valid held high and DATA_W=64, strb=8'h0F -> second command accepted the cycle after done, WSTRB=8'h0F, no overlap of transactions.
- With AXI4L_WR_TIMEOUT_EN and TIMEOUT_CYC=16, BVALID withheld for 40 cycles -> timeout=1 at the 16th cycle and stays high, BREADY remains 1, completion still pulses done, timeout clears on the next command.
